mvm_out_requant: RTL and testbench
==================================

Name: mvm_out_requant

Overview:
- Downstream stage of the 32x32 8-bit matrix-vector multiplier (mvm_32_32_8_1).
- Watches the MVM `done` pulse and captures the K 2b-bit results the MVM streams on `data_out` in the K cycles after done rises.
- Rescales each result (rounding arithmetic right shift), applies optional ReLU and saturates to OB bits.
- Buffers the K results and presents them in order on a valid/ready stream with a last marker, decoupling the MVM from the next layer's back-pressure.

Parameters:
- K, 32, vector length = number of results per burst.
- b, 8, MVM input width; MVM result width is 2*b.
- OB, 8, output element width.
- SW, $clog2(2*b), width of the shift-amount port.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- mvm_done  in  1  MVM done flag; only its rising edge is used.
- mvm_data  in  2*b  MVM data_out, signed.
- cfg_shift  in  SW  right-shift amount, sampled at done rise.
- cfg_relu  in  1  ReLU enable, sampled at done rise.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer ready.
- out_data  out  OB  processed element, signed.
- out_last  out  1  high with element K-1.
- busy  out  1  high in CAPTURE or DRAIN.
- overrun  out  1  sticky error: burst started while not IDLE.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - out_valid=0, out_data=0, out_last=0, busy=0, overrun=0.
  - State IDLE, indices 0, done_q=0.
  - Buffer contents need not be cleared.
- Edge detect: done_q registers mvm_done every cycle. A rise is mvm_done=1 with done_q=0.
- State IDLE:
  - On a rise, latch cfg_shift and cfg_relu, set wr_idx=0, go to CAPTURE.
  - The rise cycle itself captures nothing.
- State CAPTURE: on each of the next K rising edges:
  - buf[wr_idx] <= proc(mvm_data); wr_idx++.
  - After the edge that writes index K-1, go to DRAIN with rd_idx=0.
  - out_valid rises in the cycle after the last capture edge; latency from rise to first out_valid is K+1 edges.
- proc(y), 2b+1-bit signed intermediate:
  - t = (y + (s>0 ? 2^(s-1) : 0)) >>> s, i.e. round half toward +inf.
  - If relu, t<0 becomes 0.
  - Saturate to [-2^(OB-1), 2^(OB-1)-1].
  - s=0 is a pass-through apart from saturation.
- State DRAIN:
  - out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==K-1).
  - On out_valid&&out_ready, rd_idx++.
  - The handshake on rd_idx==K-1 returns to IDLE; out_valid=0 the next cycle.
  - While out_ready=0, out_data and out_last hold stable.
- Overrun: a done rise seen in CAPTURE or DRAIN sets overrun=1 (cleared only by reset). That burst is ignored; the in-progress capture or drain continues unaffected.
- busy = (state != IDLE).
- A done rise in the same cycle as the final DRAIN handshake counts as overrun; a new burst must start after IDLE is reached.
- mvm_done held high does not retrigger; it must fall and rise again.

Test Plan:
- Passthrough/saturation: shift=0, relu=0, y = 5, -3, 127, -128, 300, -200, then 0 for the rest → out_data 5, -3, 127, -128, 127, -128, 0..., out_last only on element 31, first out_valid K+1 edges after the done rise.
- Rounding: shift=4, y = 24, -24, 23, -25, 8, -8 → 2, -1, 1, -2, 1, 0.
- ReLU: relu=1, shift=0, y = -5, 0, 1000, -32768, 42 → 0, 0, 127, 0, 42.
- Back-pressure: out_ready toggling 1,0,1,0... plus a 10-cycle stall at element 7 → all 32 elements in order with no duplicates, data/last stable during stalls, return to IDLE (busy=0) after the 32nd handshake.
- Overrun: pulse mvm_done again during DRAIN at element 3 → overrun=1 and stays 1, remaining elements 4..31 match the first burst, second burst data never emitted.
- Reset mid-capture: drive reset=0 between clock edges after 10 captures → out_valid, busy, overrun go 0 immediately; after reset=1 a fresh burst with y=i (0..31), shift=0 yields out_data 0..31.

Source files
------------

// File: rtl/mvm_out_requant.sv
// Output stage for the 32x32 8-bit MVM.
// Captures the K-result burst that follows a done rise, then rescales each result with a
// rounding right shift, applies optional ReLU and saturates it. The results are buffered
// and replayed on a valid/ready stream, with a last marker on the final element.
module mvm_out_requant #(
    parameter int unsigned K  = 32,
    parameter int unsigned b  = 8,
    parameter int unsigned OB = 8,
    parameter int unsigned SW = $clog2(2 * b)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mvm_done,
    input  logic signed [2*b-1:0] mvm_data,
    input  logic        [SW-1:0] cfg_shift,
    input  logic                 cfg_relu,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OB-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned YW = 2 * b;
    // One extra bit so that adding the rounding constant can never overflow.
    localparam int unsigned IW = YW + 1;
    localparam int unsigned AW = (K > 1) ? $clog2(K) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(K - 1);
    localparam logic signed [IW-1:0] MaxV = IW'((2 ** (OB - 1)) - 1);
    localparam logic signed [IW-1:0] MinV = ~MaxV;

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e                state_q;
    logic                  done_q;
    logic [SW-1:0]         shift_q;
    logic                  relu_q;
    logic [AW-1:0]         wr_idx_q;
    logic [AW-1:0]         rd_idx_q;
    logic signed [OB-1:0]  mem_q [K];

    logic                  done_rise;
    logic signed [IW-1:0]  y_ext;
    logic signed [IW-1:0]  rnd;
    logic signed [IW-1:0]  sum;
    logic signed [IW-1:0]  shifted;
    logic signed [IW-1:0]  relu_v;
    logic signed [OB-1:0]  proc_val;

    assign done_rise = mvm_done & ~done_q;
    assign busy      = (state_q != StIdle);

    // Requantise the incoming result: round half toward +inf, shift, ReLU, saturate.
    always_comb begin
        y_ext = {mvm_data[YW-1], mvm_data};
        rnd   = '0;
        if (shift_q != '0) begin
            rnd = IW'(1) << (shift_q - SW'(1));
        end
        sum     = y_ext + rnd;
        shifted = sum >>> shift_q;
        relu_v  = (relu_q && shifted[IW-1]) ? '0 : shifted;
        if (relu_v > MaxV) begin
            proc_val = MaxV[OB-1:0];
        end else if (relu_v < MinV) begin
            proc_val = MinV[OB-1:0];
        end else begin
            proc_val = relu_v[OB-1:0];
        end
    end

    // Result buffer; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (state_q == StCapture) begin
            mem_q[wr_idx_q] <= proc_val;
        end
    end

    // Control FSM with registered stream outputs and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_q <= mvm_done;
            // A burst arriving while busy is dropped; only the flag records it.
            if (done_rise && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (done_rise) begin
                        shift_q  <= cfg_shift;
                        relu_q   <= cfg_relu;
                        wr_idx_q <= '0;
                        state_q  <= StCapture;
                    end
                end
                StCapture: begin
                    wr_idx_q <= wr_idx_q + AW'(1);
                    if (wr_idx_q == LastIdx) begin
                        state_q   <= StDrain;
                        rd_idx_q  <= '0;
                        out_valid <= 1'b1;
                        // With K == 1 element 0 is being written on this very edge.
                        out_data  <= (wr_idx_q == '0) ? proc_val : mem_q[0];
                        out_last  <= (LastIdx == '0);
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (rd_idx_q == LastIdx) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            rd_idx_q <= rd_idx_q + AW'(1);
                            out_data <= mem_q[rd_idx_q + AW'(1)];
                            out_last <= ((rd_idx_q + AW'(1)) == LastIdx);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_out_requant.sv
// Directed bench for mvm_out_requant: one task per scenario, inline comparisons.
module tb_mvm_out_requant;

    localparam int K = 32;

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic               mvm_done  = 1'b0;
    logic signed [15:0] mvm_data  = '0;
    logic        [3:0]  cfg_shift = '0;
    logic               cfg_relu  = 1'b0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               out_last;
    logic               busy;
    logic               overrun;

    int                errors = 0;
    int                checks = 0;
    int                ydata [K];
    int                expv [K];
    logic signed [7:0] got [K];
    logic              got_last [K];
    int                ngot;
    logic              valid_early;

    mvm_out_requant dut (
        .clk       (clk),
        .reset     (reset),
        .mvm_done  (mvm_done),
        .mvm_data  (mvm_data),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Pulse done, then present ydata[0..K-1] on the K following edges; returns one
    // negedge after the last capture edge. valid_early flags any premature out_valid.
    task automatic launch(input int sh, input bit rl);
        valid_early = 1'b0;
        @(negedge clk);
        mvm_done  = 1'b1;
        cfg_shift = 4'(sh);
        cfg_relu  = rl;
        for (int i = 0; i < K; i++) begin
            @(negedge clk);
            valid_early = valid_early | out_valid;
            mvm_done    = 1'b0;
            mvm_data    = 16'(ydata[i]);
        end
        @(negedge clk);
    endtask

    // Always-ready drain into got[]/got_last[], bounded in cycles.
    task automatic drain_all();
        int cyc;
        cyc  = 0;
        ngot = 0;
        while (ngot < K && cyc < 4 * K) begin
            out_ready = 1'b1;
            if (out_valid) begin
                got[ngot]      = out_data;
                got_last[ngot] = out_last;
                ngot++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < K; i++) begin ydata[i] = 0; expv[i] = 0; end
        ydata[0] = 5;   ydata[1] = -3;   ydata[2] = 127;
        ydata[3] = -128; ydata[4] = 300; ydata[5] = -200;
        expv[0] = 5;    expv[1] = -3;    expv[2] = 127;
        expv[3] = -128; expv[4] = 127;   expv[5] = -128;
        launch(0, 1'b0);
        checks++;
        if (valid_early !== 1'b0) begin errors++; $display("FAIL pt_latency_early valid seen before K+1 edges"); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pt_latency valid got %b want 1", out_valid); end
        drain_all();
        checks++;
        if (ngot != K) begin errors++; $display("FAIL pt_count got %0d want %0d", ngot, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i])) begin
                errors++; $display("FAIL pt_data[%0d] got %0d want %0d", i, got[i], expv[i]);
            end
            checks++;
            if (got_last[i] !== (i == K - 1)) begin
                errors++; $display("FAIL pt_last[%0d] got %b want %b", i, got_last[i], i == K - 1);
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL pt_idle busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_rounding();
        for (int i = 0; i < K; i++) begin ydata[i] = 0; expv[i] = 0; end
        ydata[0] = 24; ydata[1] = -24; ydata[2] = 23; ydata[3] = -25; ydata[4] = 8; ydata[5] = -8;
        expv[0] = 2;   expv[1] = -1;   expv[2] = 1;   expv[3] = -2;   expv[4] = 1; expv[5] = 0;
        launch(4, 1'b0);
        drain_all();
        checks++;
        if (ngot != K) begin errors++; $display("FAIL rnd_count got %0d want %0d", ngot, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i])) begin
                errors++; $display("FAIL rnd_data[%0d] got %0d want %0d", i, got[i], expv[i]);
            end
        end
    endtask

    task automatic test_relu();
        for (int i = 0; i < K; i++) begin ydata[i] = 0; expv[i] = 0; end
        ydata[0] = -5; ydata[1] = 0; ydata[2] = 1000; ydata[3] = -32768; ydata[4] = 42;
        expv[2] = 127; expv[4] = 42;
        launch(0, 1'b1);
        drain_all();
        checks++;
        if (ngot != K) begin errors++; $display("FAIL relu_count got %0d want %0d", ngot, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i])) begin
                errors++; $display("FAIL relu_data[%0d] got %0d want %0d", i, got[i], expv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int                n;
        int                cyc;
        int                stall;
        bit                tog;
        bit                pend;
        logic signed [7:0] pd;
        logic              pl;
        for (int i = 0; i < K; i++) begin ydata[i] = 3 * i - 40; expv[i] = 3 * i - 40; end
        launch(0, 1'b0);
        n = 0; cyc = 0; stall = 10; tog = 1'b1; pend = 1'b0; pd = '0; pl = 1'b0;
        while (n < K && cyc < 400) begin
            if (pend) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                    errors++;
                    $display("FAIL bp_stable[%0d] valid=%b data=%0d last=%b want 1 %0d %b",
                             n, out_valid, out_data, out_last, pd, pl);
                end
            end
            if (n == 7 && stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = tog;
                tog = ~tog;
            end
            if (out_valid && out_ready) begin
                got[n] = out_data; got_last[n] = out_last; n++; pend = 1'b0;
            end else begin
                pend = out_valid; pd = out_data; pl = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (n != K) begin errors++; $display("FAIL bp_count got %0d want %0d", n, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i]) || got_last[i] !== (i == K - 1)) begin
                errors++;
                $display("FAIL bp_elem[%0d] got %0d/%b want %0d/%b", i, got[i], got_last[i],
                         expv[i], i == K - 1);
            end
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_overrun();
        int n;
        int cyc;
        int stray;
        bit pulsed;
        for (int i = 0; i < K; i++) begin ydata[i] = i + 1; expv[i] = i + 1; end
        launch(0, 1'b0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got %b want 0", overrun); end
        n = 0; cyc = 0; pulsed = 1'b0;
        mvm_data = 16'sd99;
        while (n < K && cyc < 200) begin
            out_ready = 1'b1;
            mvm_done  = (n == 3) && !pulsed;
            if (mvm_done) pulsed = 1'b1;
            if (out_valid) begin got[n] = out_data; n++; end
            @(negedge clk);
            cyc++;
        end
        mvm_done = 1'b0;
        checks++;
        if (n != K) begin errors++; $display("FAIL ovr_count got %0d want %0d", n, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i])) begin
                errors++; $display("FAIL ovr_data[%0d] got %0d want %0d", i, got[i], expv[i]);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) stray++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (stray != 0) begin errors++; $display("FAIL ovr_no_second got %0d valid cycles want 0", stray); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_capture();
        for (int i = 0; i < K; i++) begin ydata[i] = i; expv[i] = i; end
        @(negedge clk);
        mvm_done  = 1'b1;
        cfg_shift = 4'd0;
        cfg_relu  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mvm_done = 1'b0;
            mvm_data = 16'(ydata[i]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
        @(negedge clk);
        reset = 1'b1;
        launch(0, 1'b0);
        drain_all();
        checks++;
        if (ngot != K) begin errors++; $display("FAIL rst_fresh_count got %0d want %0d", ngot, K); end
        for (int i = 0; i < K; i++) begin
            checks++;
            if (got[i] !== 8'(expv[i])) begin
                errors++; $display("FAIL rst_fresh_data[%0d] got %0d want %0d", i, got[i], expv[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rounding();
        test_relu();
        test_backpressure();
        test_overrun();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
